// File: rtl/mmio_if_mc_if.sv
// MCU-side 8-bit MMIO bus bundle for mmio_if_mc.
// Master drives strobes/address/data; slave returns registered read data and irq.
interface mmio_if_mc_if #(
  parameter int AW = 8
) ();
  logic          cs;
  logic          rd;
  logic          wr;
  logic [AW-1:0] addr;
  logic [7:0]    wdata;
  logic [7:0]    rdata;
  logic          rvalid;
  logic          irq;

  modport master (
    output cs, rd, wr, addr, wdata,
    input  rdata, rvalid, irq
  );

  modport slave (
    input  cs, rd, wr, addr, wdata,
    output rdata, rvalid, irq
  );
endinterface

// File: rtl/mmio_if_mc.sv
// Multi-channel MMIO shadow for N fuzzy cores with double-buffered thresholds.
// Optional write-once threshold lock: define MMIO_THR_LOCK_EN.
module mmio_if_mc #(
  parameter int NCH  = 2,
  parameter int DW   = 8,
  parameter int NTHR = 24,
  parameter int AW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mmio_if_mc_if.slave       bus,
  output logic              start,
  output logic              init,
  output logic              reg_mode,
  output logic              dt_mode,
  output logic [NCH*DW-1:0] T_in,
  output logic [NCH*DW-1:0] dT_in,
  output logic [NTHR*DW-1:0] thr_act,
  input  logic              done,
  input  logic [NCH*8-1:0]  G_in
);

  localparam logic [AW-1:0] A_STATUS = AW'(0);
  localparam logic [AW-1:0] A_CTRL   = AW'(1);
  localparam logic [AW-1:0] A_CHSEL  = AW'(2);
  localparam logic [AW-1:0] A_T      = AW'(3);
  localparam logic [AW-1:0] A_G      = AW'(4);
  localparam logic [AW-1:0] A_DT     = AW'(5);
  localparam int            A_THR    = 16;

  // {neg,zero,pos} x {a,b,c,d}, first entry in the top byte
  localparam logic [95:0] RST_TAB =
    96'h80_80_C0_00_C0_00_00_40_00_40_80_80;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [DW-1:0] thr_rst(int i);
    logic [7:0] v;
    v = RST_TAB[(11 - (i % 12))*8 +: 8];
    return DW'($signed(v));
  endfunction

  state_t state, state_nx;

  logic [DW-1:0] t_reg  [NCH];
  logic [DW-1:0] dt_reg [NCH];
  logic [DW-1:0] shadow [NTHR];
  logic [DW-1:0] act    [NTHR];
  logic [7:0]    ch_sel;
  logic          irq_en;
  logic          commit;
  logic          done_f;
  logic          err_f;
  logic          cpend;
  logic          lock;

  logic [7:0]    wd;
  logic [DW-1:0] wd_x;
  logic          acc_wr;
  logic          acc_rd;
  logic          is_thr;
  logic          wr_status;
  logic          wr_ctrl;
  logic          wr_chsel;
  logic          wr_t;
  logic          wr_dt;
  logic          wr_thr;
  logic          bad_wr;
  logic          sel_ok;
  logic          busy;
  logic          busy_now;
  logic          start_req;
  logic          start_nx;
  logic          commit_nx;
  logic          lock_err;
  logic          fall;
  logic          copy;
  logic          done_nx;
  logic          err_nx;
  logic          cpend_nx;
  logic [7:0]    status;
  logic [7:0]    ctrl_rd;
  logic [DW-1:0] cur_t;
  logic [DW-1:0] cur_dt;
  logic [7:0]    cur_g;
  logic [7:0]    thr_rd;
  logic [7:0]    rd_val;

  assign wd   = bus.wdata;
  assign wd_x = DW'($signed(wd));
  assign busy = (state == RUN);

  always_comb begin
    acc_wr    = bus.cs & bus.wr;
    acc_rd    = bus.cs & bus.rd;
    is_thr    = (int'(bus.addr) >= A_THR) &&
                (int'(bus.addr) < A_THR + NTHR);
    wr_status = acc_wr & (bus.addr == A_STATUS);
    wr_ctrl   = acc_wr & (bus.addr == A_CTRL);
    wr_chsel  = acc_wr & (bus.addr == A_CHSEL);
    wr_t      = acc_wr & (bus.addr == A_T);
    wr_dt     = acc_wr & (bus.addr == A_DT) & ~dt_mode;
    wr_thr    = acc_wr & is_thr & ~lock;
    bad_wr    = acc_wr & ~is_thr &
                (bus.addr != A_STATUS) & (bus.addr != A_CTRL) &
                (bus.addr != A_CHSEL) & (bus.addr != A_T) &
                (bus.addr != A_DT);
    sel_ok    = int'(wd) < NCH;
  end

  // a start pulse already in flight counts as busy
  always_comb begin
    busy_now  = busy | start;
    start_req = wr_ctrl & wd[0];
    start_nx  = start_req & ~busy_now;
    commit_nx = wr_ctrl & wd[4] & ~lock;
    lock_err  = lock & ((acc_wr & is_thr) | (wr_ctrl & wd[4]));
    fall      = busy & done & ~init;
    copy      = (commit & ~(busy_now & ~init)) |
                ((cpend | commit) & fall);
    if (init) begin
      cpend_nx = 1'b0;
    end else if (copy) begin
      cpend_nx = 1'b0;
    end else if (commit) begin
      cpend_nx = 1'b1;
    end else begin
      cpend_nx = cpend;
    end
    done_nx = (done_f & ~(wr_status & wd[0])) | done;
    err_nx  = (err_f & ~(wr_status & wd[1])) |
              bad_wr | (wr_chsel & ~sel_ok) |
              (start_req & busy_now) | lock_err;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (init) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

`ifdef MMIO_THR_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                lock <= 1'b0;
    else if (wr_ctrl & wd[6])  lock <= 1'b1;
  end
`else
  assign lock = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start    <= 1'b0;
      init     <= 1'b0;
      commit   <= 1'b0;
      reg_mode <= 1'b1;
      dt_mode  <= 1'b1;
      irq_en   <= 1'b0;
      ch_sel   <= 8'd0;
      done_f   <= 1'b0;
      err_f    <= 1'b0;
      cpend    <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        t_reg[k]  <= '0;
        dt_reg[k] <= '0;
      end
      for (int i = 0; i < NTHR; i++) begin
        shadow[i] <= thr_rst(i);
        act[i]    <= thr_rst(i);
      end
    end else begin
      start  <= start_nx;
      init   <= wr_ctrl & wd[3];
      commit <= commit_nx;
      if (wr_ctrl) begin
        reg_mode <= wd[1];
        dt_mode  <= wd[2];
        irq_en   <= wd[5];
      end
      if (wr_chsel & sel_ok) ch_sel <= wd;
      for (int k = 0; k < NCH; k++) begin
        if (wr_t && ch_sel == 8'(k))  t_reg[k]  <= wd_x;
        if (wr_dt && ch_sel == 8'(k)) dt_reg[k] <= wd_x;
      end
      for (int i = 0; i < NTHR; i++) begin
        if (wr_thr && bus.addr == AW'(A_THR + i)) shadow[i] <= wd_x;
        if (copy) act[i] <= shadow[i];
      end
      done_f <= done_nx;
      err_f  <= err_nx;
      cpend  <= cpend_nx;
    end
  end

  always_comb begin
    cur_t  = '0;
    cur_dt = '0;
    cur_g  = 8'd0;
    thr_rd = 8'd0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_sel == 8'(k)) begin
        cur_t  = t_reg[k];
        cur_dt = dt_reg[k];
        cur_g  = G_in[k*8 +: 8];
      end
    end
    for (int i = 0; i < NTHR; i++) begin
      if (bus.addr == AW'(A_THR + i)) thr_rd = shadow[i][7:0];
    end
    status  = {3'b000, lock, busy, cpend, err_f, done_f};
    ctrl_rd = {1'b0, lock, irq_en, 2'b00, dt_mode, reg_mode, 1'b0};
    unique case (1'b1)
      bus.addr == A_STATUS: rd_val = status;
      bus.addr == A_CTRL:   rd_val = ctrl_rd;
      bus.addr == A_CHSEL:  rd_val = ch_sel;
      bus.addr == A_T:      rd_val = cur_t[7:0];
      bus.addr == A_G:      rd_val = cur_g;
      bus.addr == A_DT:     rd_val = cur_dt[7:0];
      is_thr:               rd_val = thr_rd;
      default:              rd_val = 8'd0;
    endcase
  end

  // readback samples pre-write state, so rd&wr returns the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rdata  <= 8'd0;
      bus.rvalid <= 1'b0;
      bus.irq    <= 1'b0;
    end else begin
      bus.rvalid <= acc_rd;
      if (acc_rd) bus.rdata <= rd_val;
      bus.irq <= irq_en & done_f;
    end
  end

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      T_in[k*DW +: DW]  = t_reg[k];
      dT_in[k*DW +: DW] = dt_reg[k];
    end
    for (int i = 0; i < NTHR; i++) begin
      thr_act[i*DW +: DW] = act[i];
    end
  end

endmodule

// File: tb/tb_mmio_if_mc.sv
// Scoreboard bench for mmio_if_mc: reads queue expectations, a monitor pops them.
// Scenario tasks also check pulses, status flags and core-side outputs inline.
module tb_mmio_if_mc;
  localparam int NCH  = 2;
  localparam int DW   = 8;
  localparam int NTHR = 24;
  localparam int AW   = 8;

  localparam logic [95:0] EXP_TAB =
    96'h80_80_C0_00_C0_00_00_40_00_40_80_80;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } rexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start, init, reg_mode, dt_mode, done;
  logic [NCH*DW-1:0]  T_in, dT_in;
  logic [NTHR*DW-1:0] thr_act;
  logic [NCH*8-1:0]   G_in;

  int tests = 0;
  int fails = 0;
  rexp_t exp_q[$];

  mmio_if_mc_if #(.AW(AW)) bus ();

  mmio_if_mc #(.NCH(NCH), .DW(DW), .NTHR(NTHR), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .start(start), .init(init), .reg_mode(reg_mode), .dt_mode(dt_mode),
    .T_in(T_in), .dT_in(dT_in), .thr_act(thr_act),
    .done(done), .G_in(G_in)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst_n && bus.rvalid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rvalid_unexpected rdata=%h required no read", bus.rdata);
      end else begin
        rexp_t e;
        e = exp_q.pop_front();
        if (bus.rdata !== e.d) begin
          fails++;
          $display("FAIL read_%h got %h required %h", e.a, bus.rdata, e.d);
        end
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cs = 1; bus.wr = 1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.cs = 0; bus.wr = 0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] d);
    rexp_t e;
    @(negedge clk);
    bus.cs = 1; bus.rd = 1; bus.addr = a;
    e.a = a; e.d = d;
    exp_q.push_back(e);
    @(negedge clk);
    bus.cs = 0; bus.rd = 0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    done = 1;
    @(negedge clk);
    done = 0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    bus.cs = 0; bus.rd = 0; bus.wr = 0; bus.addr = 0; bus.wdata = 0;
    done = 0;
    G_in = {8'd77, 8'd42};
    #12;
    tests++;
    if ({start, init, bus.irq, bus.rvalid, bus.rdata} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outs got %b required 0", {start, init, bus.irq, bus.rvalid});
    end
    tests++;
    if ({reg_mode, dt_mode} !== 2'b11 || T_in !== '0 || dT_in !== '0) begin
      fails++;
      $display("FAIL reset_modes got %b T=%h dT=%h required 11 0 0", {reg_mode, dt_mode}, T_in, dT_in);
    end
    for (int i = 0; i < NTHR; i++) begin
      e = EXP_TAB[(11 - (i % 12))*8 +: 8];
      tests++;
      if (thr_act[i*DW +: DW] !== e) begin
        fails++;
        $display("FAIL reset_thr_%0d got %h required %h", i, thr_act[i*DW +: DW], e);
      end
    end
    @(negedge clk);
    rst_n = 1;
    rd(8'h10, 8'h80);
    rd(8'h14, 8'hC0);
    rd(8'h18, 8'h00);
    rd(8'h1B, 8'h80);
    rd(8'h00, 8'h00);
    rd(8'h40, 8'h00);
  endtask

  task automatic test_chsel();
    wr(8'h02, 8'h01);
    wr(8'h03, 8'h25);
    rd(8'h03, 8'h25);
    tests++;
    if (T_in[15:8] !== 8'h25 || T_in[7:0] !== 8'h00) begin
      fails++;
      $display("FAIL t_in got %h required 2500", T_in);
    end
    wr(8'h05, 8'h33);
    rd(8'h05, 8'h00);
    rd(8'h04, 8'd77);
    wr(8'h02, 8'h02);
    rd(8'h02, 8'h01);
    rd(8'h00, 8'h02);
    wr(8'h00, 8'h02);
    wr(8'h04, 8'h11);
    rd(8'h00, 8'h02);
    wr(8'h00, 8'h02);
    rd(8'h00, 8'h00);
  endtask

  task automatic test_commit();
    wr(8'h11, 8'h90);
    rd(8'h11, 8'h90);
    wr(8'h01, 8'h13);
    tests++;
    if (start !== 1'b1) begin
      fails++;
      $display("FAIL start_pulse got %b required 1", start);
    end
    @(negedge clk);
    tests++;
    if (start !== 1'b0) begin
      fails++;
      $display("FAIL start_width got %b required 0", start);
    end
    rd(8'h00, 8'h0C);
    tests++;
    if (thr_act[15:8] !== 8'h80) begin
      fails++;
      $display("FAIL thr_hold got %h required 80", thr_act[15:8]);
    end
    pulse_done();
    tests++;
    if (thr_act[15:8] !== 8'h90) begin
      fails++;
      $display("FAIL thr_deferred got %h required 90", thr_act[15:8]);
    end
    rd(8'h00, 8'h01);
    wr(8'h12, 8'h55);
    wr(8'h01, 8'h12);
    tests++;
    if (thr_act[23:16] !== 8'hC0) begin
      fails++;
      $display("FAIL thr_pre_commit got %h required C0", thr_act[23:16]);
    end
    @(negedge clk);
    tests++;
    if (thr_act[23:16] !== 8'h55) begin
      fails++;
      $display("FAIL thr_idle_commit got %h required 55", thr_act[23:16]);
    end
  endtask

  task automatic test_irq();
    wr(8'h00, 8'h01);
    wr(8'h01, 8'h22);
    pulse_done();
    @(negedge clk);
    tests++;
    if (bus.irq !== 1'b1) begin
      fails++;
      $display("FAIL irq_set got %b required 1", bus.irq);
    end
    wr(8'h00, 8'h01);
    @(negedge clk);
    tests++;
    if (bus.irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_clr got %b required 0", bus.irq);
    end
    @(negedge clk);
    bus.cs = 1; bus.wr = 1; bus.addr = 8'h00; bus.wdata = 8'h01;
    done = 1;
    @(negedge clk);
    bus.cs = 0; bus.wr = 0; done = 0;
    rd(8'h00, 8'h01);
  endtask

  task automatic test_busy();
    wr(8'h00, 8'h03);
    wr(8'h01, 8'h03);
    rd(8'h00, 8'h08);
    wr(8'h01, 8'h03);
    tests++;
    if (start !== 1'b0) begin
      fails++;
      $display("FAIL start_busy got %b required 0", start);
    end
    rd(8'h00, 8'h0A);
    wr(8'h13, 8'h11);
    wr(8'h01, 8'h12);
    rd(8'h00, 8'h0E);
    wr(8'h01, 8'h0A);
    tests++;
    if (init !== 1'b1) begin
      fails++;
      $display("FAIL init_pulse got %b required 1", init);
    end
    rd(8'h00, 8'h02);
    tests++;
    if (thr_act[31:24] !== 8'h00) begin
      fails++;
      $display("FAIL thr_after_init got %h required 00", thr_act[31:24]);
    end
  endtask

  task automatic test_back_to_back();
    wr(8'h00, 8'hFF);
    wr(8'h05, 8'h44);
    tests++;
    if (dT_in[15:8] !== 8'h44 || dT_in[7:0] !== 8'h00) begin
      fails++;
      $display("FAIL dt_in got %h required 4400", dT_in);
    end
    @(negedge clk);
    bus.cs = 1; bus.rd = 1; bus.addr = 8'h14;
    exp_q.push_back('{8'h14, 8'hC0});
    @(negedge clk);
    bus.addr = 8'h05;
    exp_q.push_back('{8'h05, 8'h44});
    @(negedge clk);
    bus.addr = 8'h12;
    exp_q.push_back('{8'h12, 8'h55});
    @(negedge clk);
    bus.wr = 1; bus.addr = 8'h15; bus.wdata = 8'h66;
    exp_q.push_back('{8'h15, 8'h00});
    @(negedge clk);
    bus.cs = 0; bus.rd = 0; bus.wr = 0;
    rd(8'h15, 8'h66);
  endtask

  task automatic test_reset_mid();
    wr(8'h01, 8'h13);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    tests++;
    if ({start, init, bus.rvalid, reg_mode, dt_mode} !== 5'b00011) begin
      fails++;
      $display("FAIL async_reset got %b required 00011", {start, init, bus.rvalid, reg_mode, dt_mode});
    end
    tests++;
    if (thr_act[15:8] !== 8'h80 || T_in !== '0 || dT_in !== '0) begin
      fails++;
      $display("FAIL async_reset_regs thr1=%h T=%h dT=%h required 80 0 0", thr_act[15:8], T_in, dT_in);
    end
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    rd(8'h00, 8'h00);
    rd(8'h11, 8'h80);
    rd(8'h02, 8'h00);
  endtask

  task automatic test_lock();
`ifdef MMIO_THR_LOCK_EN
    wr(8'h01, 8'h42);
    wr(8'h10, 8'h00);
    wr(8'h01, 8'h12);
    rd(8'h10, 8'h80);
    rd(8'h00, 8'h12);
`else
    wr(8'h01, 8'h42);
    wr(8'h10, 8'h00);
    rd(8'h10, 8'h00);
    rd(8'h00, 8'h00);
`endif
  endtask

  initial begin
    test_reset();
    test_chsel();
    test_commit();
    test_irq();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    test_lock();
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL read_pending got %0d required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mmio_if_mc.md
Name: mmio_if_mc

Overview:
- Parametrised multi-channel successor of the MCU-facing MMIO shadow. Sits between the 8-bit MCU bus and N fuzzy-core instances.
- Adds double-buffered membership thresholds, committed atomically and only when the core is idle.
- Adds per-channel T/dT/G via a channel-select window, a sticky DONE/ERR status with W1C, a level IRQ, and registered readback with 1-cycle latency.

Parameters:
- NCH, 2, number of core channels (1..8).
- DW, 8, data/threshold width in bits (8..16). Bus registers use the low 8 bits; the upper bits are sign-extended on write.
- NTHR, 24, threshold count: 12 for T, 12 for dT, each ordered {neg,zero,pos} x {a,b,c,d}.
- AW, 8, address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cs  in  1  chip select.
- rd  in  1  read strobe.
- wr  in  1  write strobe.
- addr  in  AW  register address.
- wdata  in  8  write data.
- rdata  out  8  registered read data.
- rvalid  out  1  high one cycle after an accepted read.
- irq  out  1  level interrupt.
- start  out  1  one-cycle start pulse to all channels.
- init  out  1  one-cycle init pulse.
- reg_mode  out  1  rule-set select.
- dt_mode  out  1  internal-dT select.
- T_in  out  NCH*DW  per-channel T, channel k at [k*DW +: DW].
- dT_in  out  NCH*DW  per-channel dT.
- thr_act  out  NTHR*DW  active thresholds, index i at [i*DW +: DW].
- done  in  1  one-cycle completion pulse from the core.
- G_in  in  NCH*8  per-channel G (0..100).

Behaviour:
- Address map:
  - 0x00 STATUS (R, W1C): [0]DONE [1]ERR [2]CPEND [3]BUSY [4]LOCK.
  - 0x01 CTRL (W): [0]START W1P, [1]REG_MODE, [2]DT_MODE, [3]INIT W1P, [4]COMMIT W1P, [5]IRQ_EN.
  - 0x02 CH_SEL (RW).
  - 0x03 T[CH_SEL] (RW).
  - 0x04 G[CH_SEL] (RO).
  - 0x05 dT[CH_SEL] (RW; write ignored while dt_mode=1).
  - 0x10..0x10+NTHR-1: shadow thresholds (RW).
- Reset values:
  - rdata=0, rvalid=0, irq=0, start=0, init=0.
  - reg_mode=1, dt_mode=1, IRQ_EN=0, CH_SEL=0, all T/dT=0, DONE/ERR/CPEND/BUSY/LOCK=0.
  - Shadow and active thresholds per triplet (sign-extended to DW): neg={80,80,C0,00}, zero={C0,00,00,40}, pos={00,40,80,80}.
- Writes complete in one cycle.
  - START/INIT/COMMIT bits are registered pulses, high for exactly one cycle after the write.
  - Writing 0 to a W1P bit has no effect.
- BUSY FSM, states IDLE and RUN:
  - IDLE->RUN on the start pulse.
  - RUN->IDLE on done.
  - init forces IDLE and clears CPEND.
  - done while IDLE sets DONE only.
- Status flags:
  - DONE is set on the done input.
  - STATUS write clears bits where wdata=1. If a clear and a set occur in the same cycle, set wins.
  - ERR is set by any of: a write to an unmapped or RO address; a CH_SEL write >= NCH (value kept unchanged); START while BUSY (pulse suppressed).
- Commit:
  - If BUSY=0, thr_act <= shadow on the cycle after the COMMIT pulse.
  - If BUSY=1, CPEND=1 and the copy happens in the cycle BUSY falls. CPEND then clears.
  - A shadow write while CPEND=1 is included in the deferred copy.
  - thr_act never changes while BUSY=1.
- Reads:
  - rdata and rvalid are registered one cycle after cs&rd.
  - Unmapped reads return 0 with rvalid=1.
  - cs&rd&wr together: the write takes effect and the read returns the pre-write value.
- irq = IRQ_EN & DONE, registered.
- Asynchronous reset mid-RUN or mid-CPEND returns every register to its reset value; no pending commit survives reset.

Optional Feature:
- Macro: MMIO_THR_LOCK_EN.
- When defined:
  - CTRL[6] is a write-once LOCK, cleared only by rst_n.
  - While LOCK=1, shadow threshold writes and COMMIT are ignored and set ERR.
  - STATUS[4] reflects LOCK.
- When undefined, CTRL[6] is ignored and STATUS[4] reads 0.

Test Plan:
- Reset, then read 0x10, 0x14, 0x18 -> rdata 0x80, 0xC0, 0x00 one cycle later with rvalid=1. Read 0x00 -> 0x00.
- Write CH_SEL=1, write 0x03=0x25, read 0x03 -> 0x25. T_in ch1=0x25 and ch0 stays 0. Write CH_SEL=NCH -> ERR=1, CH_SEL stays 1.
- Write 0x11=0x90, then CTRL=0x13 (START|REG_MODE|COMMIT) -> BUSY=1, CPEND=1, thr_act[1] still 0x80. Pulse done -> thr_act[1]=0x90 next cycle, CPEND=0, DONE=1.
- CTRL IRQ_EN=1, pulse done -> irq=1. Write STATUS=0x01 -> irq=0. Clear coincident with done -> DONE stays 1.
- START while BUSY -> no start pulse, ERR=1. INIT -> init pulse, BUSY=0, CPEND=0.
- With MMIO_THR_LOCK_EN: write CTRL[6]=1, then 0x10=0x00 -> shadow unchanged, ERR=1, STATUS[4]=1.
